// File: rtl/seed_pkg.sv
// Shared types and constants for the SEED host-side sequencer.
package seed_pkg;

  localparam int TEXT_W      = 128;
  localparam int TIMEOUT_DEF = 48;

  typedef enum logic [2:0] {
    IDLE  = 3'h0,
    START = 3'h1,
    KEY   = 3'h2,
    WAIT  = 3'h3,
    RESP  = 3'h4
  } state_t;

endpackage

// File: rtl/seed_host_ctrl.sv
// SEED core sequencer: text beat, key beat, wait for done; response 2 cycles + core latency after accept.
// Response is held in RESP until i_fRspReady (no limit); requests are refused outside IDLE.
module seed_host_ctrl
  import seed_pkg::*;
#(
  parameter int TEXT_W  = seed_pkg::TEXT_W,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 6
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_fReqValid,
  output logic              o_fReqReady,
  input  logic [TEXT_W-1:0] i_ReqText,
  input  logic [TEXT_W-1:0] i_ReqKey,
  input  logic              i_fReqDec,
  output logic [TEXT_W-1:0] o_CoreText,
  output logic              o_fCoreStart,
  output logic              o_fCoreDec,
  input  logic [TEXT_W-1:0] i_CoreText,
  input  logic              i_fCoreDone,
  output logic              o_fRspValid,
  input  logic              i_fRspReady,
  output logic [TEXT_W-1:0] o_RspText,
  output logic              o_fRspDec,
  output logic              o_fTimeout
);

  typedef struct packed {
    logic [TEXT_W-1:0] text;
    logic [TEXT_W-1:0] key;
    logic              dec;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q;
  logic [TEXT_W-1:0] rsp_text_q;
  logic              rsp_timeout_q;
  logic [CNT_W-1:0]  wdog_q;
  logic              wdog_end;

  assign wdog_end = (wdog_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    o_fReqReady  = 1'b0;
    o_fCoreStart = 1'b0;
    o_CoreText   = '0;
    o_fCoreDec   = 1'b0;
    o_fRspValid  = 1'b0;
    o_RspText    = '0;
    o_fRspDec    = 1'b0;
    o_fTimeout   = 1'b0;
    case (state_q)
      IDLE: begin
        o_fReqReady = 1'b1;
        if (i_fReqValid) state_d = START;
      end
      START: begin
        o_fCoreStart = 1'b1;
        o_CoreText   = req_q.text;
        o_fCoreDec   = req_q.dec;
        state_d      = KEY;
      end
      KEY: begin
        o_CoreText = req_q.key;
        o_fCoreDec = req_q.dec;
        state_d    = WAIT;
      end
      WAIT: begin
        o_fCoreDec = req_q.dec;
        if (i_fCoreDone || wdog_end) state_d = RESP;
      end
      RESP: begin
        o_fRspValid = 1'b1;
        o_RspText   = rsp_text_q;
        o_fRspDec   = req_q.dec;
        o_fTimeout  = rsp_timeout_q;
        if (i_fRspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Done takes priority over the watchdog terminal count in the same cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      req_q         <= '0;
      rsp_text_q    <= '0;
      rsp_timeout_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_fReqValid) req_q <= '{text: i_ReqText, key: i_ReqKey, dec: i_fReqDec};
        end
        KEY: wdog_q <= '0;
        WAIT: begin
          wdog_q <= wdog_q + CNT_W'(1);
          if (i_fCoreDone) begin
            rsp_text_q    <= i_CoreText;
            rsp_timeout_q <= 1'b0;
          end else if (wdog_end) begin
            rsp_text_q    <= '0;
            rsp_timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seed_host_ctrl.md
Name: seed_host_ctrl

Overview:
- Initiator-side sequencer for the SEED cipher core command interface.
- Accepts one request per transaction: a 128-bit block, a 128-bit key and an enc/dec flag, over a valid/ready stream.
- Drives the core's two-beat start protocol (text beat, then key beat) and waits for the core's done pulse.
- Captures the core result and returns it on a valid/ready response stream. Includes a watchdog that flags a core that never completes.

Parameters:
- TEXT_W, 128, block and key width.
- TIMEOUT, 48, maximum cycles spent in WAIT before the timeout response; must be ≥ 40.
- CNT_W, 6, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  synchronous reset, active-high.
- i_fReqValid  in  1  request valid.
- o_fReqReady  out  1  request ready; high only in IDLE.
- i_ReqText  in  TEXT_W  plaintext or ciphertext block.
- i_ReqKey  in  TEXT_W  cipher key.
- i_fReqDec  in  1  1 = decrypt, 0 = encrypt.
- o_CoreText  out  TEXT_W  to core text input.
- o_fCoreStart  out  1  to core start input; single-cycle pulse.
- o_fCoreDec  out  1  to core decrypt-select input.
- i_CoreText  in  TEXT_W  core result.
- i_fCoreDone  in  1  core done pulse.
- o_fRspValid  out  1  response valid.
- i_fRspReady  in  1  response ready.
- o_RspText  out  TEXT_W  result block; 0 on timeout.
- o_fRspDec  out  1  echo of the request's dec flag.
- o_fTimeout  out  1  qualifies the response as a watchdog timeout.

Behaviour:
- Reset (i_Rst=1 at a rising edge):
  - State goes to IDLE; all registers clear.
  - o_fReqReady=1 in the following cycle; all other outputs 0.
  - Reset mid-transaction abandons it silently; no response is produced.
- States: IDLE, START, KEY, WAIT, RESP.
- IDLE:
  - o_fReqReady=1.
  - On i_fReqValid & o_fReqReady (cycle T), register text, key and dec, then go to START.
- START (T+1):
  - o_fCoreStart=1, o_CoreText=stored text, o_fCoreDec=stored dec.
  - Go to KEY unconditionally.
- KEY (T+2):
  - o_CoreText=stored key, o_fCoreStart=0, o_fCoreDec=stored dec.
  - Go to WAIT; clear the watchdog.
- WAIT:
  - o_CoreText=0, o_fCoreDec held.
  - Watchdog increments each cycle.
  - i_fCoreDone=1: capture i_CoreText into the response register, set timeout=0, go to RESP.
  - Otherwise, when the watchdog reaches TIMEOUT-1: response text=0, timeout=1, go to RESP.
  - If done and the watchdog terminal count coincide, done wins (timeout=0).
- RESP:
  - o_fRspValid=1; o_RspText, o_fRspDec and o_fTimeout are held stable while valid.
  - On i_fRspReady, go to IDLE. Backpressure may last indefinitely.
- i_fCoreDone outside WAIT is ignored (not captured, no state change).
- o_CoreText is 0 in every state except START and KEY.
- Latency with the SEED core attached, measured from the accept edge T:
  - Encrypt: core done at T+19, o_fRspValid at T+20.
  - Decrypt: core done at T+35, o_fRspValid at T+36.
- Throughput:
  - Back-to-back requests: the earliest next accept is the cycle after the response handshake.
  - That guarantees the core has returned to idle before the next start.
- After a timeout, the core state is undefined. The system must reset the core before the next request; this block does not.
- No arithmetic other than the watchdog: CNT_W-bit unsigned, cleared in KEY, with no wrap possible because the exit occurs at TIMEOUT-1.

Decomposition:
- Shared package seed_pkg holds:
  - TEXT_W.
  - State encoding constants (IDLE=3'h0, START=3'h1, KEY=3'h2, WAIT=3'h3, RESP=3'h4).
  - Default TIMEOUT.
- Single module, no sub-module: the FSM, the registers and the watchdog fit comfortably in one file.

Test Plan:
- Encrypt, SEED core attached:
  - Stimulus: key=0, text=0x000102030405060708090A0B0C0D0E0F, dec=0.
  - Required: o_fCoreStart for one cycle at T+1, key beat at T+2, o_fRspValid at T+20, o_RspText=0x5EBAC6E0054E166819AFF1CC6D346CDB, o_fTimeout=0.
- Decrypt round-trip:
  - Stimulus: feed the encrypt result back with dec=1 and the same key.
  - Required: o_fRspValid at T+36, o_RspText=0x000102030405060708090A0B0C0D0E0F, o_fRspDec=1.
- Backpressure:
  - Stimulus: hold i_fRspReady=0 for 10 cycles, then 1.
  - Required: response stable for all 10 cycles, one handshake, o_fReqReady=1 in the next cycle; a second request issued then completes correctly.
- Timeout:
  - Stimulus: core stub that never asserts done.
  - Required: o_fRspValid exactly TIMEOUT cycles after WAIT entry, o_RspText=0, o_fTimeout=1.
- Spurious done and simultaneity:
  - Stimulus: pulse i_fCoreDone in IDLE and in KEY.
  - Required: both ignored, no response.
  - Stimulus: stub done at watchdog terminal count.
  - Required: o_fTimeout=0 and the captured text is returned.
- Reset mid-operation:
  - Stimulus: assert i_Rst during WAIT.
  - Required: next cycle IDLE, o_fReqReady=1, o_fRspValid=0, o_CoreText=0; a later done pulse produces no response.
